// File: rtl/spoly_gen.sv
// rtl/spoly_gen.sv - ternary short-polynomial generator: signed fill, then Fisher-Yates shuffle in external RAM.
// Optional post-shuffle weight check is compiled in with `define SPOLY_WEIGHT_CHECK_EN.
module spoly_gen #(
  parameter int P      = 757,
  parameter int W      = 286,
  parameter int ADDR_W = 11,
  parameter int RAND_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAND_W-1:0] rand_i,
  input  logic              rand_valid,
  output logic              rand_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  output logic              mem_we,
  input  logic [1:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef SPOLY_WEIGHT_CHECK_EN
  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_DRAW, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_DRAW, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_DONE
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(P - 1);
  localparam logic [ADDR_W:0]   WEIGHT = (ADDR_W + 1)'(W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [1:0]        vi_q, vi_d;
  logic [ADDR_W-1:0] draw_r;
  logic              fill_adv;
  logic              unused_rand;

`ifdef SPOLY_WEIGHT_CHECK_EN
  localparam logic [ADDR_W:0] CHK_END = (ADDR_W + 1)'(P);
  logic [ADDR_W:0] chk_q, chk_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] cnt_nxt;
  logic            err_q, err_d;
`endif

  // Smallest all-ones value covering i: bit b is set when i has any bit at or above b.
  function automatic logic [ADDR_W-1:0] bit_mask(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] m;
    m = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      m[b] = |(v >> b);
    end
    return m;
  endfunction

  assign unused_rand = ^rand_i;

  always_comb begin
    draw_r = rand_i[ADDR_W-1:0] & bit_mask(i_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      vi_q    <= '0;
`ifdef SPOLY_WEIGHT_CHECK_EN
      chk_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      vi_q    <= vi_d;
`ifdef SPOLY_WEIGHT_CHECK_EN
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    i_d        = i_q;
    j_d        = j_q;
    vi_d       = vi_q;
    fill_adv   = 1'b0;
    rand_ready = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 2'b00;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
`ifdef SPOLY_WEIGHT_CHECK_EN
    chk_d      = chk_q;
    cnt_d      = cnt_q;
    cnt_nxt    = cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_FILL;
          k_d     = '0;
`ifdef SPOLY_WEIGHT_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end

      S_FILL: begin
        mem_addr = k_q;
        if ({1'b0, k_q} < WEIGHT) begin
          // Signed ones take their sign from bit 0 of the random word.
          rand_ready = 1'b1;
          if (rand_valid) begin
            mem_we    = 1'b1;
            mem_wdata = rand_i[0] ? 2'b11 : 2'b01;
            fill_adv  = 1'b1;
          end
        end else begin
          mem_we   = 1'b1;
          fill_adv = 1'b1;
        end
        if (fill_adv) begin
          if (k_q == LAST) begin
            state_d = S_DRAW;
            i_d     = LAST;
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end
      end

      S_DRAW: begin
        // Masked draws above i are rejected so j stays uniform over 0..i.
        rand_ready = 1'b1;
        if (rand_valid && (draw_r <= i_q)) begin
          j_d     = draw_r;
          state_d = S_RD_I;
        end
      end

      S_RD_I: begin
        mem_addr = i_q;
        state_d  = S_RD_J;
      end

      S_RD_J: begin
        mem_addr = j_q;
        vi_d     = mem_rdata;
        state_d  = S_WR_I;
      end

      S_WR_I: begin
        mem_addr  = i_q;
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
        state_d   = S_WR_J;
      end

      S_WR_J: begin
        mem_addr  = j_q;
        mem_we    = 1'b1;
        mem_wdata = vi_q;
        if (i_q > ADDR_W'(1)) begin
          i_d     = i_q - ADDR_W'(1);
          state_d = S_DRAW;
        end else begin
`ifdef SPOLY_WEIGHT_CHECK_EN
          chk_d   = '0;
          cnt_d   = '0;
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end

`ifdef SPOLY_WEIGHT_CHECK_EN
      S_CHECK: begin
        // Data read at chk-1 arrives now, so the sweep runs one cycle past the last address.
        mem_addr = (chk_q == CHK_END) ? '0 : chk_q[ADDR_W-1:0];
        if ((chk_q != '0) && (mem_rdata != 2'b00)) begin
          cnt_nxt = cnt_q + (ADDR_W + 1)'(1);
        end
        cnt_d = cnt_nxt;
        if (chk_q == CHK_END) begin
          err_d   = (cnt_nxt != WEIGHT);
          state_d = S_DONE;
        end else begin
          chk_d = chk_q + (ADDR_W + 1)'(1);
        end
      end
`endif

      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef SPOLY_WEIGHT_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spoly_gen.sv
// tb/tb_spoly_gen.sv - bench for spoly_gen: hand vectors at P=8/W=3 plus random runs and a default-size run against a shuffle model.
module tb_spoly_gen;
  localparam int SP = 8, SW = 3, SA = 4;
  localparam int BP = 757, BW = 286, BA = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, rand_valid, rand_ready, mem_we, busy, done, err;
  logic [31:0]   rand_i;
  logic [SA-1:0] mem_addr;
  logic [1:0]    mem_wdata, mem_rdata;

  logic          b_start, b_rand_valid, b_rand_ready, b_mem_we, b_busy, b_done, b_err;
  logic [31:0]   b_rand_i;
  logic [BA-1:0] b_mem_addr;
  logic [1:0]    b_mem_wdata, b_mem_rdata;

  spoly_gen #(.P(SP), .W(SW), .ADDR_W(SA), .RAND_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rand_i(rand_i), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err));

  spoly_gen dut_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .rand_i(b_rand_i), .rand_valid(b_rand_valid),
    .rand_ready(b_rand_ready), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .done(b_done), .err(b_err));

  logic [1:0] ram [0:15];
  logic [1:0] b_ram [0:2047];
  logic       ram_clr, b_clr;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int a = 0; a < 16; a++) ram[a] <= 2'b10;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (b_clr) begin
      for (int a = 0; a < 2048; a++) b_ram[a] <= 2'b10;
    end else if (b_mem_we) begin
      b_ram[b_mem_addr] <= b_mem_wdata;
    end
    b_mem_rdata <= b_ram[b_mem_addr];
  end

  logic [31:0] wq [0:4095];
  logic [1:0]  exp_ram [0:2047];
  int total = 0, bad = 0;
  int stall_viol = 0, busy_at_done = 0;

  typedef struct packed {
    logic [15:0][31:0] w;
    int                mode;
    logic [7:0][1:0]   exp;
    int                used;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  // Reference: signed fill from the word stream, then Fisher-Yates with power-of-two rejection.
  task automatic model(input int p, input int w, output int used);
    int r, m, b;
    logic [1:0] t;
    used = 0;
    for (int k = 0; k < p; k++) begin
      if (k < w) begin
        exp_ram[k] = wq[used][0] ? 2'b11 : 2'b01;
        used++;
      end else begin
        exp_ram[k] = 2'b00;
      end
    end
    for (int i = p - 1; i >= 1; i--) begin
      b = 0;
      while ((1 << b) <= i) b++;
      m = (1 << b) - 1;
      r = i + 1;
      while (r > i && used < 4096) begin
        r = int'(wq[used] & 32'(m));
        used++;
      end
      t = exp_ram[i];
      exp_ram[i] = exp_ram[r];
      exp_ram[r] = t;
    end
  endtask

  task automatic run_small(input int mode, input bit mid_start, output int used, output int dpulses, output int bcyc);
    bit fin;
    int after;
    used = 0; dpulses = 0; bcyc = 0; fin = 0; after = 0;
    ram_clr = 1'b1;
    @(negedge clk);
    ram_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && after < 2; cyc++) begin
      case (mode)
        0:       rand_valid = 1'b1;
        1:       rand_valid = (cyc % 2 == 0);
        default: rand_valid = ($urandom_range(0, 3) != 0);
      endcase
      rand_i = wq[used];
      start = mid_start && (cyc == 20);
      #1;
      if (rand_ready && !rand_valid && mem_we) stall_viol++;
      if (rand_valid && rand_ready) used++;
      if (busy) bcyc++;
      if (done) begin
        dpulses++;
        if (busy) busy_at_done++;
        fin = 1'b1;
      end
      if (fin) after++;
      @(negedge clk);
    end
    rand_valid = 1'b0;
    start = 1'b0;
    chk("done_seen", int'(fin), 1);
  endtask

  function automatic int extra_check(input int p);
`ifdef SPOLY_WEIGHT_CHECK_EN
    return p + 1;
`else
    return 0 * p;
`endif
  endfunction

  initial begin
    int used, dp, bc, mu, mism, nz;
    bit hit, fin;
    logic [31:0] lfsr;

    vecs[0].w = '0; vecs[0].mode = 0; vecs[0].used = 10;
    vecs[0].exp = {2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    vecs[1] = vecs[0]; vecs[1].mode = 1;
    vecs[2].w = '0; vecs[2].mode = 0; vecs[2].used = 10;
    vecs[2].w[0] = 32'hFFFF_FFF1; vecs[2].w[1] = 32'h0000_0002; vecs[2].w[2] = 32'h1234_5671;
    for (int k = 0; k < 7; k++) vecs[2].w[3 + k] = 32'(7 - k);
    vecs[2].exp = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b11};
    vecs[3].w = '0; vecs[3].mode = 0; vecs[3].used = 12;
    vecs[3].w[3] = 32'hABCD_000F; vecs[3].w[4] = 32'd6;
    vecs[3].w[5] = 32'hFFFF_FFF7; vecs[3].w[6] = 32'd6; vecs[3].w[7] = 32'd2;
    vecs[3].w[8] = 32'd4; vecs[3].w[9] = 32'd3; vecs[3].w[10] = 32'd2; vecs[3].w[11] = 32'd1;
    vecs[3].exp = {2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};

    rst_n = 1'b0; start = 1'b0; rand_valid = 1'b0; rand_i = '0; ram_clr = 1'b0;
    b_start = 1'b0; b_rand_valid = 1'b0; b_rand_i = '0; b_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_ready", int'(rand_ready), 0);
    chk("rst_addr", int'(mem_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 64; k++) wq[k] = (k < 16) ? vecs[v].w[k] : 32'd0;
      run_small(vecs[v].mode, 1'b0, used, dp, bc);
      for (int a = 0; a < SP; a++)
        chk($sformatf("vec%0d_ram%0d", v, a), int'(ram[a]), int'(vecs[v].exp[a]));
      chk($sformatf("vec%0d_used", v), used, vecs[v].used);
      chk($sformatf("vec%0d_done_pulses", v), dp, 1);
      chk($sformatf("vec%0d_err", v), int'(err), 0);
      if (vecs[v].mode == 0)
        chk($sformatf("vec%0d_busy_cycles", v), bc, SP + (vecs[v].used - SW) + 4 * (SP - 1) + extra_check(SP));
    end

    for (int k = 0; k < 64; k++) wq[k] = 32'd0;
    ram_clr = 1'b1; @(negedge clk); ram_clr = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    used = 0; hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      rand_valid = 1'b1;
      rand_i = wq[used];
      #1;
      if (used >= 4 && mem_we) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", int'(mem_we), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(rand_ready), 0);
        hit = 1'b1;
      end else begin
        if (rand_valid && rand_ready) used++;
        @(negedge clk);
      end
    end
    chk("rst_mid_reached", int'(hit), 1);
    rand_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_small(0, 1'b0, used, dp, bc);
    for (int a = 0; a < SP; a++)
      chk($sformatf("after_rst_ram%0d", a), int'(ram[a]), int'(vecs[0].exp[a]));
    chk("after_rst_done_pulses", dp, 1);

    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 128; k++) wq[k] = $urandom;
      run_small(t % 3, (t % 5 == 0), used, dp, bc);
      model(SP, SW, mu);
      mism = 0;
      for (int a = 0; a < SP; a++) if (ram[a] !== exp_ram[a]) mism++;
      chk($sformatf("rnd%0d_ram_mismatches", t), mism, 0);
      chk($sformatf("rnd%0d_used", t), used, mu);
      chk($sformatf("rnd%0d_done_pulses", t), dp, 1);
      chk($sformatf("rnd%0d_err", t), int'(err), 0);
    end

    lfsr = 32'h1;
    for (int k = 0; k < 4096; k++) begin
      wq[k] = lfsr;
      for (int s = 0; s < 32; s++) lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    end
    b_clr = 1'b1; @(negedge clk); b_clr = 1'b0;
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    used = 0; bc = 0; dp = 0; fin = 1'b0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      b_rand_valid = 1'b1;
      b_rand_i = wq[used];
      #1;
      if (b_rand_ready) used++;
      if (b_busy) bc++;
      if (b_done) begin dp++; fin = 1'b1; end
      @(negedge clk);
    end
    b_rand_valid = 1'b0;
    chk("big_done", int'(fin), 1);
    chk("big_err", int'(b_err), 0);
    model(BP, BW, mu);
    mism = 0; nz = 0;
    for (int a = 0; a < BP; a++) begin
      if (b_ram[a] !== exp_ram[a]) mism++;
      if (b_ram[a] == 2'b01 || b_ram[a] == 2'b11) nz++;
    end
    chk("big_ram_mismatches", mism, 0);
    chk("big_weight", nz, BW);
    chk("big_used", used, mu);
    chk("big_busy_cycles", bc, BP + (used - BW) + 4 * (BP - 1) + extra_check(BP));
    chk("big_busy_min", int'(bc >= BP + 4 * (BP - 1) + (BP - 1)), 1);

    chk("stall_write_count", stall_viol, 0);
    chk("busy_during_done", busy_at_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
